piso_tx: RTL and testbench

Parallel-in/serial-out transmitter that feeds the `sipo` shift register. It accepts WIDTH-bit words over a valid/ready handshake into a one-word holding buffer. It shifts each word out MSB first, one bit per `shift_en` cycle, and reloads from the buffer without a gap so back-to-back words stream continuously. MSB-first order means a downstream `sipo` clocked with `ie = shift_en & active` holds the original word after WIDTH bits.

---
 rtl/piso_tx.sv | 81 ++++++++
 tb/tb_piso_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: one-word holding buffer behind a valid/ready
// port, MSB-first shifting on shift_en, gapless reload between consecutive words.
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             active,
  output logic             frame_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    cnt;

  // Handshake: a word transfers on an edge where din_valid && din_ready are both high.
  // din_ready only depends on the buffer being empty (and reset being low), never on
  // din_valid, and the source must keep din stable until the transfer.
  assign din_ready  = !hold_full && !rst;
  assign active     = (state == SHIFT);
  assign sout       = shreg[WIDTH-1];
  assign frame_last = active && (cnt == LAST);
  assign busy       = active || hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      // Accept only happens with hold empty, so it never collides with a transfer below.
      if (din_valid && din_ready) begin
        hold      <= din;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hold_full) begin
            shreg     <= hold;
            cnt       <= '0;
            hold_full <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt != LAST) begin
              shreg <= {shreg[WIDTH-2:0], 1'b0};
              cnt   <= cnt + CW'(1);
            end else if (hold_full) begin
              shreg     <= hold;
              cnt       <= '0;
              hold_full <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: directed scenarios plus random traffic, checked against a
// bit-queue model and a receiver scoreboard that reassembles words from sout.
module tb_piso_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         shift_en;
  logic         sout;
  logic         active;
  logic         frame_last;
  logic         busy;

  piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .shift_en   (shift_en),
    .sout       (sout),
    .active     (active),
    .frame_last (frame_last),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model and scoreboard state ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic         m_bits[$];   // bits of the word currently on the line, MSB first
  logic [W-1:0] m_hold[$];   // at most one buffered word
  logic [W-1:0] exp_q[$];    // accepted words awaiting reception
  logic         m_fresh;     // nothing loaded since reset, so sout must read 0
  logic [W-1:0] rx;
  logic         last_acc;
  int           act_cnt;
  int           cyc;
  int           first_act;
  int           last_act;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_load(input logic [W-1:0] w);
    m_bits.delete();
    for (int i = W - 1; i >= 0; i--) m_bits.push_back(w[i]);
    m_fresh = 1'b0;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic se);
    logic         acc;
    logic         had;
    logic [W-1:0] hw;
    rst       = r;
    din_valid = v;
    din       = d;
    shift_en  = se;
    #1;
    check("din_ready", din_ready, (!r && m_hold.size() == 0));
    acc = !r && v && (m_hold.size() == 0);
    if (!r && se && m_bits.size() > 0) begin
      rx = {rx[W-2:0], sout};
      if (m_bits.size() == 1) begin
        if (exp_q.size() == 0) check("rx_unexpected", rx, ~rx);
        else check("rx_word", rx, exp_q.pop_front());
      end
    end
    @(posedge clk);
    if (r) begin
      m_bits.delete();
      m_hold.delete();
      exp_q.delete();
      m_fresh = 1'b1;
      rx      = '0;
    end else begin
      had = (m_hold.size() > 0);
      hw  = had ? m_hold[0] : '0;
      if (m_bits.size() == 0) begin
        if (had) begin
          m_load(hw);
          void'(m_hold.pop_front());
        end
      end else if (se) begin
        void'(m_bits.pop_front());
        if (m_bits.size() == 0 && had) begin
          m_load(hw);
          void'(m_hold.pop_front());
        end
      end
      if (acc) begin
        m_hold.push_back(d);
        exp_q.push_back(d);
      end
    end
    last_acc = acc;
    #1;
    check("active", active, (m_bits.size() > 0));
    check("frame_last", frame_last, (m_bits.size() == 1));
    check("busy", busy, (m_bits.size() > 0 || m_hold.size() > 0));
    if (m_bits.size() > 0) check("sout", sout, m_bits[0]);
    else if (m_fresh) check("sout_rst", sout, 1'b0);
    cyc++;
    if (active) begin
      act_cnt++;
      if (first_act < 0) first_act = cyc;
      last_act = cyc;
    end
  endtask

  task automatic clear_stats();
    act_cnt   = 0;
    first_act = -1;
    last_act  = -1;
  endtask

  // Offers words in order (valid held until accepted); period 1 = shift every cycle,
  // otherwise shift_en is high on cycles where j % period == 1.
  task automatic send_stream(input logic [W-1:0] words[$], input int period, input int budget);
    int   k = 0;
    int   j = 0;
    logic se;
    while ((k < words.size() || m_bits.size() > 0 || m_hold.size() > 0) && j < budget) begin
      se = (period <= 1) ? 1'b1 : ((j % period) == 1);
      if (k < words.size()) begin
        step(1'b0, 1'b1, words[k], se);
        if (last_acc) k++;
      end else begin
        step(1'b0, 1'b0, '0, se);
      end
      j++;
    end
    if (j >= budget) check("stream_timeout", W'(j), W'(budget - 1));
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  // ---------------- scenarios ----------------
  logic [W-1:0] words[$];
  logic         rv;
  logic [W-1:0] rw;

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = '0; shift_en = 1'b0;
    m_fresh = 1'b1; rx = '0; last_acc = 1'b0; cyc = 0;
    clear_stats();
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b1);

    // single word
    clear_stats();
    words = '{8'hA5};
    send_stream(words, 1, 30);
    check("single_len", W'(act_cnt), W'(8));

    // back-to-back
    clear_stats();
    words = '{8'hA5, 8'h3C};
    send_stream(words, 1, 40);
    check("b2b_len", W'(act_cnt), W'(16));
    check("b2b_span", W'(last_act - first_act + 1), W'(16));

    // throttled
    clear_stats();
    words = '{8'h81};
    send_stream(words, 3, 60);
    check("throttle_len", W'(act_cnt), W'(24));

    // backpressure
    words = '{8'h11, 8'h22, 8'h33};
    send_stream(words, 1, 60);
    check("bp_drained", W'(exp_q.size()), W'(0));

    // reset mid-word
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    check("rst_mid_busy", W'(busy), W'(0));
    words = '{8'h5A};
    send_stream(words, 1, 30);

    // random loopback traffic
    rv = 1'b0;
    rw = '0;
    for (int c = 0; c < 500; c++) begin
      if (!rv && $urandom_range(0, 2) == 0) begin
        rv = 1'b1;
        rw = W'($urandom_range(0, 255));
      end
      step(1'b0, rv, rw, 1'($urandom_range(0, 1)));
      if (last_acc) rv = 1'b0;
    end
    for (int c = 0; c < 60 && (m_bits.size() > 0 || m_hold.size() > 0); c++)
      step(1'b0, 1'b0, '0, 1'b1);
    check("final_drained", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
